gpio_top_core: RTL and testbench



---
 rtl/gpio_top_core_if.sv | 16 +
 rtl/gpio_top_core.sv | 72 +++++++
 tb/tb_gpio_top_core.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/gpio_top_core_if.sv
`default_nettype none
// ============================================================================
// Module  : gpio_top_core_if
// Brief   : Word-addressed GPIO bus: address, write strobe/data, read data.
// Revision: 1.0 - initial release
// ============================================================================
interface gpio_top_core_if;
    logic [1:0]  a;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output a, output we, output wd, input rd);
    modport slave  (input a, input we, input wd, output rd);
endinterface
`default_nettype wire

// File: rtl/gpio_top_core.sv
`default_nettype none
// ============================================================================
// Module  : gpio_top_core
// Brief   : Two pass-through input words and two writable output registers
//           behind a 2-bit word-address bus with a combinational read mux.
// Revision: 1.0 - initial release
// ============================================================================
module gpio_top_core (
    input  wire logic              clk,
    input  wire logic              rst,
    gpio_top_core_if.slave         bus,
    input  wire logic [31:0]       gpI1_i,
    input  wire logic [31:0]       gpI2_i,
    output      logic [31:0]       gpO1_o,
    output      logic [31:0]       gpO2_o
);

    localparam logic [1:0]  c_ADDR_GPI1 = 2'd0;
    localparam logic [1:0]  c_ADDR_GPI2 = 2'd1;
    localparam logic [1:0]  c_ADDR_GPO1 = 2'd2;
    localparam logic [1:0]  c_ADDR_GPO2 = 2'd3;
    localparam logic [31:0] c_RESET_VAL = 32'h0000_0000;

    logic [31:0] gpo1_q, gpo1_d;
    logic [31:0] gpo2_q, gpo2_d;
    logic        w_we_gpo1;
    logic        w_we_gpo2;
    logic [31:0] w_rd;

    // Input-port addresses have no decode term, so writes there are dropped.
    assign w_we_gpo1 = bus.we && (bus.a == c_ADDR_GPO1);
    assign w_we_gpo2 = bus.we && (bus.a == c_ADDR_GPO2);

    always_comb begin
        gpo1_d = gpo1_q;
        gpo2_d = gpo2_q;
        if (w_we_gpo1) begin
            gpo1_d = bus.wd;
        end
        if (w_we_gpo2) begin
            gpo2_d = bus.wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gpo1_q <= c_RESET_VAL;
            gpo2_q <= c_RESET_VAL;
        end else begin
            gpo1_q <= gpo1_d;
            gpo2_q <= gpo2_d;
        end
    end

    // Read path ignores we, so a same-cycle write reads back the old value.
    always_comb begin
        w_rd = c_RESET_VAL;
        case (bus.a)
            c_ADDR_GPI1: w_rd = gpI1_i;
            c_ADDR_GPI2: w_rd = gpI2_i;
            c_ADDR_GPO1: w_rd = gpo1_q;
            c_ADDR_GPO2: w_rd = gpo2_q;
            default:     w_rd = c_RESET_VAL;
        endcase
    end

    assign bus.rd = w_rd;
    assign gpO1_o = gpo1_q;
    assign gpO2_o = gpo2_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_top_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpio_top_core
// Brief   : Directed bench for gpio_top_core with a per-cycle reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gpio_top_core;

    logic        clk;
    logic        rst;
    logic [31:0] gpI1;
    logic [31:0] gpI2;
    logic [31:0] gpO1;
    logic [31:0] gpO2;

    gpio_top_core_if bus ();

    gpio_top_core dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .gpI1_i (gpI1),
        .gpI2_i (gpI2),
        .gpO1_o (gpO1),
        .gpO2_o (gpO2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: output words indexed by (address - 2).
    logic [31:0] m_out [2];
    bit          m_ok = 1'b0;

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            m_out[0] = 32'h0;
            m_out[1] = 32'h0;
            m_ok     = 1'b1;
        end else if (bus.we === 1'b1 && bus.a >= 2'd2) begin
            m_out[int'(bus.a) - 2] = bus.wd;
        end
    end

    function automatic logic [31:0] model_rd(input logic [1:0] addr);
        if (addr == 2'd0)      return gpI1;
        else if (addr == 2'd1) return gpI2;
        else                   return m_out[int'(addr) - 2];
    endfunction

    always @(negedge clk) begin
        if (m_ok) begin
            check("model_gpO1", gpO1, m_out[0]);
            check("model_gpO2", gpO2, m_out[1]);
            check("model_rd", bus.rd, model_rd(bus.a));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b0;
        bus.we = 1'b1;
        bus.a  = 2'd2;
        bus.wd = 32'd170;
        gpI1   = 32'd0;
        gpI2   = 32'd0;

        // Reset dominates a concurrent write.
        tick(2);
        check("rst_gpO1", gpO1, 32'd0);
        check("rst_gpO2", gpO2, 32'd0);
        check("rst_rd_a2", bus.rd, 32'd0);

        // Input reads; writes to 0/1 must not touch any register.
        rst  = 1'b1;
        bus.a = 2'd0;
        gpI1 = 32'd168;
        #1;
        check("in1_comb", bus.rd, 32'd168);
        tick(2);
        check("in1_rd", bus.rd, 32'd168);
        bus.a = 2'd1;
        gpI2  = 32'd169;
        tick(2);
        check("in2_rd", bus.rd, 32'd169);
        check("in_wr_gpO1", gpO1, 32'd0);
        check("in_wr_gpO2", gpO2, 32'd0);

        // Output writes.
        bus.a  = 2'd2;
        bus.wd = 32'd170;
        tick(1);
        check("wr1_gpO1", gpO1, 32'd170);
        check("wr1_rd", bus.rd, 32'd170);
        bus.a  = 2'd3;
        bus.wd = 32'd171;
        tick(1);
        check("wr2_gpO2", gpO2, 32'd171);
        check("wr2_rd", bus.rd, 32'd171);
        check("wr2_gpO1", gpO1, 32'd170);

        // Write disabled.
        bus.we = 1'b0;
        bus.a  = 2'd2;
        bus.wd = 32'hDEAD_BEEF;
        tick(2);
        check("wdis_gpO1", gpO1, 32'd170);
        bus.a = 2'd3;
        #1;
        check("wdis_rd_a3", bus.rd, 32'd171);

        // Input change while addressed propagates combinationally.
        bus.a = 2'd0;
        gpI1  = 32'h1234_5678;
        #1;
        check("in_prop", bus.rd, 32'h1234_5678);

        // Read during write returns old value until the edge.
        bus.we = 1'b1;
        bus.a  = 2'd2;
        bus.wd = 32'd5;
        #1;
        check("rdw_before", bus.rd, 32'd170);
        tick(1);
        check("rdw_after", bus.rd, 32'd5);

        // Back-to-back writes to different registers.
        bus.wd = 32'd170;
        tick(1);
        bus.a  = 2'd3;
        bus.wd = 32'd171;
        tick(1);
        check("b2b_gpO1", gpO1, 32'd170);
        check("b2b_gpO2", gpO2, 32'd171);

        // Reset mid-operation with a concurrent write.
        rst    = 1'b0;
        bus.a  = 2'd3;
        bus.wd = 32'd9;
        tick(1);
        check("mid_rst_gpO1", gpO1, 32'd0);
        check("mid_rst_gpO2", gpO2, 32'd0);
        rst = 1'b1;
        tick(1);
        check("post_rst_gpO2", gpO2, 32'd9);
        check("post_rst_gpO1", gpO1, 32'd0);

        bus.we = 1'b0;
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
